dvs_event_scheduler: RTL

Sits between the DVS AER receiver and the RAVENS spike-injection interface.
- Buffers decoded DVS events in a circular FIFO.
- Releases events downstream over a valid/ready handshake.
- Divides time into fixed windows of WINDOW_US microseconds. It emits a one-cycle tick to advance the RAVENS timestep only after every event belonging to the closing window has been delivered.

---
 rtl/dvs_event_scheduler.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dvs_event_scheduler.sv
// DVS event scheduler: buffers decoded AER events in a circular FIFO, releases them
// over valid/ready, and emits a timestep tick once each window's events are delivered.
module dvs_event_scheduler #(
  parameter int FIFO_DEPTH        = 16,
  parameter int WINDOW_US         = 1000,
  parameter int DROP_CNT_BITS     = 16,
  parameter int DVS_X_ADDR_BITS   = 9,
  parameter int DVS_Y_ADDR_BITS   = 9,
  parameter int TIMESTAMP_US_BITS = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [TIMESTAMP_US_BITS-1:0]     time_us,
  input  logic                             in_new_event,
  input  logic [DVS_X_ADDR_BITS-1:0]       in_event_x,
  input  logic [DVS_Y_ADDR_BITS-1:0]       in_event_y,
  input  logic [TIMESTAMP_US_BITS-1:0]     in_event_timestamp,
  input  logic                             in_event_polarity,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [DVS_X_ADDR_BITS-1:0]       out_x,
  output logic [DVS_Y_ADDR_BITS-1:0]       out_y,
  output logic [TIMESTAMP_US_BITS-1:0]     out_timestamp,
  output logic                             out_polarity,
  output logic                             tick,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic [DROP_CNT_BITS-1:0]         drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = TIMESTAMP_US_BITS;
  localparam int XW = DVS_X_ADDR_BITS;
  localparam int YW = DVS_Y_ADDR_BITS;
  localparam int EW = XW + YW + TW + 1;

  typedef enum logic [1:0] {IDLE, ARM, STREAM, TICK} state_t;

  state_t          state;
  logic [TW-1:0]   window_end;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [EW-1:0]   mem [FIFO_DEPTH];

  logic [EW-1:0]   head;
  logic [XW-1:0]   head_x;
  logic [YW-1:0]   head_y;
  logic [TW-1:0]   head_ts;
  logic            head_pol;
  logic            empty;
  logic            full;
  logic            head_due;
  logic            window_done;
  logic            active;
  logic            pop;
  logic            push;
  logic            drop;

  // Wrap-safe ordering: a is before b when the difference lands in the upper half.
  function automatic logic is_before(input logic [TW-1:0] a, input logic [TW-1:0] b);
    logic [TW-1:0] diff;
    diff = a - b;
    return diff[TW-1];
  endfunction

  assign head = mem[rd_ptr];
  assign {head_x, head_y, head_ts, head_pol} = head;

  always_comb begin
    empty       = (fifo_count == '0);
    full        = (fifo_count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
    head_due    = is_before(head_ts, window_end);
    out_valid   = (state == STREAM) && !empty && head_due;
    pop         = out_valid && out_ready;
    active      = enable && (state != IDLE);
    push        = active && in_new_event && (!full || pop);
    drop        = active && in_new_event && full && !pop;
    window_done = !is_before(time_us, window_end) && (empty || !head_due);
  end

  assign out_x         = empty ? '0 : head_x;
  assign out_y         = empty ? '0 : head_y;
  assign out_timestamp = empty ? '0 : head_ts;
  assign out_polarity  = empty ? 1'b0 : head_pol;
  assign tick          = (state == TICK);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_event_x, in_event_y, in_event_timestamp, in_event_polarity};
  end

  // Dropping enable flushes the buffer but keeps the overflow history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      window_end <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
    end else if (!enable) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      case (state)
        IDLE: state <= ARM;
        ARM: begin
          window_end <= time_us + TW'(WINDOW_US);
          state      <= STREAM;
        end
        STREAM: if (window_done) state <= TICK;
        TICK: begin
          window_end <= window_end + TW'(WINDOW_US);
          state      <= STREAM;
        end
        default: state <= IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

endmodule
